// File: rtl/xor_stream_decoder.sv
// Unmasks a 16-bit word stream with a per-frame Galois LFSR keystream: 1-cycle latency, single output register.
// Backpressure: in_ready drops whenever the held output is not being taken. Optional checksum port via XOR_DEC_CHECKSUM_EN.
module xor_stream_decoder #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] frame_len,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
`ifdef XOR_DEC_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] checksum
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
`ifdef XOR_DEC_CHECKSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;
`endif

    logic [WIDTH-1:0] seed_sel;
    logic [WIDTH-1:0] key_next;
    logic [WIDTH-1:0] plain;
    logic             in_hs;
    logic             out_hs;

    assign seed_sel = (seed_in == '0) ? SEED_DEFAULT : seed_in;
    assign key_next = (key_q >> 1) ^ (key_q[0] ? TAPS : '0);
    assign plain    = in_data ^ key_q;

    // Ready is combinational from out_ready so a full-rate stream needs only the one output register.
    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready) && (count_q < len_q);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        key_d       = key_q;
        count_d     = count_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef XOR_DEC_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    seed_d = seed_sel;
                end
                if (start) begin
                    len_d   = frame_len;
                    key_d   = seed_load ? seed_sel : seed_q;
                    count_d = '0;
                    state_d = (frame_len != '0) ? RUN : DONE;
`ifdef XOR_DEC_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            RUN: begin
                if (in_hs) begin
                    out_data_d  = plain;
                    out_valid_d = 1'b1;
                    out_last_d  = (count_q == len_q - 16'd1);
                    count_d     = count_q + 16'd1;
                    key_d       = key_next;
`ifdef XOR_DEC_CHECKSUM_EN
                    csum_d      = csum_q ^ plain;
`endif
                    if (count_q == len_q - 16'd1) begin
                        state_d = DRAIN;
                    end
                end else if (out_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seed_q      <= SEED_DEFAULT;
            key_q       <= SEED_DEFAULT;
            count_q     <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef XOR_DEC_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            key_q       <= key_d;
            count_q     <= count_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef XOR_DEC_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
`ifdef XOR_DEC_CHECKSUM_EN
    assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Directed + randomized bench for xor_stream_decoder; expected words come from a per-frame keystream list.
module tb_xor_stream_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [15:0] frame_len;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef XOR_DEC_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] cur_seed;
    logic [15:0] capt[$];

    always #5 clk = ~clk;

    xor_stream_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .frame_len (frame_len),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef XOR_DEC_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] k);
        return (k >> 1) ^ (k[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] capt_at(input int i);
        return (i < capt.size()) ? capt[i] : 16'h0000;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge with the DUT idle; leaves it idle again, after the done pulse.
    task automatic run_frame(input int len, input bit use_fixed, input logic [15:0] fixed,
                             input bit do_load, input logic [15:0] load_val,
                             input int vld_pct, input int rdy_pct, input int hold_cycles);
        logic [15:0] win[$];
        logic [15:0] exp[$];
        logic [15:0] k, w, csum;
        int          nin, nout, cyc, hold;
        bit          in_hs, out_hs, prev_in_hs;
        if (do_load) cur_seed = (load_val == 16'h0000) ? 16'hACE1 : load_val;
        k    = cur_seed;
        csum = 16'h0000;
        for (int i = 0; i < len; i++) begin
            w = use_fixed ? fixed : 16'($urandom);
            win.push_back(w);
            exp.push_back(w ^ k);
            csum ^= w ^ k;
            k = lfsr_next(k);
        end
        capt.delete();
        start = 1'b1; frame_len = 16'(len); seed_load = do_load; seed_in = load_val;
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        start = 1'b0; seed_load = 1'b0;
        chk("busy_after_start", busy, 1);
        nin = 0; nout = 0; cyc = 0; prev_in_hs = 0; hold = hold_cycles;
        while (nout < len && cyc < len * 30 + 100) begin
            in_valid  = (nin < len) && ($urandom_range(99) < vld_pct);
            in_data   = in_valid ? win[nin] : 16'($urandom);
            out_ready = ($urandom_range(99) < rdy_pct);
            if (hold > 0 && out_valid && nout == 0) begin
                out_ready = 1'b0;
                hold--;
            end
            seed_load = 1'($urandom_range(1)); seed_in = 16'($urandom);
            start = 1'($urandom_range(1)); frame_len = 16'($urandom);
            #1;
            chk("done_mid_frame", done, 0);
            if (prev_in_hs) chk("latency_valid", out_valid, 1);
            if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
            if (nin == len) chk("in_ready_after_last", in_ready, 0);
            if (out_valid) begin
                chk("out_data", out_data, exp[nout]);
                chk("out_last", out_last, (nout == len - 1));
            end
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) capt.push_back(out_data);
            cycle();
            nin += int'(in_hs);
            nout += int'(out_hs);
            prev_in_hs = in_hs;
            cyc++;
        end
        chk("frame_timeout", nout, len);
        in_valid = 1'b0; start = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
        chk("done_pulse", done, 1);
        chk("out_valid_at_done", out_valid, 0);
        chk("busy_at_done", busy, 1);
`ifdef XOR_DEC_CHECKSUM_EN
        chk("checksum_at_done", checksum, csum);
`endif
        cycle();
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
`ifdef XOR_DEC_CHECKSUM_EN
        chk("checksum_hold", checksum, csum);
`endif
    endtask

    initial begin
        int n, cyc;
        rst = 1'b1; seed_load = 1'b1; seed_in = 16'h1234; frame_len = 16'd5; start = 1'b1;
        in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
        cur_seed = 16'hACE1;
        cycle(); cycle();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0; seed_load = 1'b0; start = 1'b0;
        cycle();

        // Keystream from the default seed
        run_frame(3, 1, 16'h0000, 0, 16'h0000, 100, 100, 0);
        chk("ks_word0", capt_at(0), 16'hACE1);
        chk("ks_word1", capt_at(1), 16'hE270);
        chk("ks_word2", capt_at(2), 16'h7138);
`ifdef XOR_DEC_CHECKSUM_EN
        chk("ks_checksum", checksum, 16'h3FA9);
`endif

        run_frame(1, 1, 16'hBED5, 0, 16'h0000, 100, 100, 0);
        chk("decode_word", capt_at(0), 16'h1234);

        run_frame(3, 1, 16'h0000, 0, 16'h0000, 100, 100, 5);
        chk("bp_word0", capt_at(0), 16'hACE1);
        chk("bp_word1", capt_at(1), 16'hE270);

        run_frame(0, 0, 16'h0000, 1, 16'h0000, 100, 100, 0);
        run_frame(1, 1, 16'h0000, 0, 16'h0000, 100, 100, 0);
        chk("zero_seed_word", capt_at(0), 16'hACE1);

        run_frame(4, 0, 16'h0000, 1, 16'h0001, 80, 80, 0);

        // Abort a frame with reset after the second accepted word
        start = 1'b1; frame_len = 16'd4; seed_load = 1'b1; seed_in = 16'h5A5A;
        cycle();
        start = 1'b0; seed_load = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 20) begin
            in_data = 16'($urandom);
            #1;
            if (in_ready) n++;
            cycle();
            cyc++;
        end
        chk("abort_words_in", n, 2);
        rst = 1'b1; in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cur_seed = 16'hACE1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        cycle();
        chk("abort_no_done", done, 0);
        run_frame(1, 1, 16'h0000, 0, 16'h0000, 100, 100, 0);
        chk("abort_new_word", capt_at(0), 16'hACE1);

        for (int f = 0; f < 8; f++) begin
            run_frame(int'($urandom_range(1, 12)), 0, 16'h0000, 1'($urandom_range(1)),
                      ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom), 70, 70, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
